// File: rtl/mix_dot_pipe_pkg.sv
// Shared constants, FSM state type and width helpers for the mix-layer dot-product engine.
// MIX_DOT_SAT_EN selects saturating arithmetic in the top level.
package mix_dot_pipe_pkg;

    localparam int N_LEN_DEF   = 16;
    localparam int N_LEN_W_DEF = 8;
    localparam int F_LEN_DEF   = 6;
    localparam int LANES_DEF   = 6;
    localparam int BEATS_DEF   = 2;
    localparam int OUTS_DEF    = 12;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_RUN   = 2'd1,
        ST_DRAIN = 2'd2,
        ST_DONE  = 2'd3
    } state_t;

    function automatic int clog2(input int value);
        int r;
        r = 0;
        for (int i = 0; i < 31; i++) begin
            if ((32'sd1 <<< i) < value) begin
                r = i + 1;
            end else begin
                r = r;
            end
        end
        return r;
    endfunction

    // Counter width that never collapses to zero bits.
    function automatic int cnt_w(input int n);
        return (clog2(n) < 1) ? 1 : clog2(n);
    endfunction

endpackage

// File: rtl/mix_dot_pipe_tree.sv
// Registered LANES-input signed adder tree with a single cycle of latency.
// Output register is held at zero whenever the engine is not running.
module mix_dot_tree #(
    parameter int LANES = 6,
    parameter int W     = 16
) (
    input  logic               i_clk,
    input  logic               i_rst,
    input  logic               i_run,
    input  logic [LANES*W-1:0] i_in,
    output logic [W-1:0]       o_sum
);

    logic [W-1:0] w_sum;
    logic [W-1:0] r_sum;

    // Two's-complement reduction; the sum width wraps by construction.
    always_comb begin
        w_sum = '0;
        for (int i = 0; i < LANES; i++) begin
            w_sum = w_sum + i_in[i*W +: W];
        end
    end

    // Sum register, cleared outside RUN/DRAIN.
    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst) begin
            r_sum <= '0;
        end else if (!i_run) begin
            r_sum <= '0;
        end else begin
            r_sum <= w_sum;
        end
    end

    assign o_sum = r_sum;

endmodule

// File: rtl/mix_dot_pipe.sv
// Streaming fixed-point dot-product engine: FSM, multipliers, accumulator, bias and result buffer.
// Define MIX_DOT_SAT_EN for wide accumulation with a clamped result; otherwise results wrap.
module mix_dot_pipe
    import mix_dot_pipe_pkg::*;
#(
    parameter int N_LEN   = N_LEN_DEF,
    parameter int N_LEN_W = N_LEN_W_DEF,
    parameter int F_LEN   = F_LEN_DEF,
    parameter int LANES   = LANES_DEF,
    parameter int BEATS   = BEATS_DEF,
    parameter int OUTS    = OUTS_DEF
) (
    input  logic                     i_clk,
    input  logic                     i_rst,
    input  logic                     i_start,
    input  logic                     i_in_valid,
    output logic                     o_in_ready,
    input  logic [LANES*N_LEN-1:0]   i_d,
    input  logic [LANES*N_LEN_W-1:0] i_w,
    input  logic [N_LEN_W-1:0]       i_b,
    output logic                     o_busy,
    output logic                     o_valid,
    output logic [OUTS*N_LEN-1:0]    o_q
);

    localparam int FULL_W = N_LEN + N_LEN_W;
    localparam int PROD_W = N_LEN + N_LEN_W - F_LEN;
`ifdef MIX_DOT_SAT_EN
    localparam int KEEP_W = PROD_W;
    localparam int SUM_W  = PROD_W + clog2(LANES * BEATS) + 1;
`else
    localparam int KEEP_W = N_LEN;
    localparam int SUM_W  = N_LEN;
`endif
    localparam int BEAT_W = cnt_w(BEATS);
    localparam int ELEM_W = cnt_w(OUTS);

    state_t r_state;
    state_t w_state_nx;
    logic   r_in_ready;
    logic   r_busy;
    logic   r_valid;

    logic [BEAT_W-1:0] r_beat;
    logic [ELEM_W-1:0] r_elem;
    logic [ELEM_W-1:0] r_k;

    logic w_accept;
    logic w_beat_last;
    logic w_frame_last;
    logic w_start_ok;
    logic w_write;
    logic w_final_wr;
    logic w_k_ok;

    logic [LANES*N_LEN-1:0]   r_d;
    logic [LANES*N_LEN_W-1:0] r_w;
    logic                     r_v0, r_v1, r_v2;
    logic                     r_l0, r_l1, r_l2;
    logic [N_LEN_W-1:0]       r_b0, r_b1, r_b2;

    logic [LANES*SUM_W-1:0] w_prod;
    logic [LANES*SUM_W-1:0] r_prod;
    logic [SUM_W-1:0]       w_tree_sum;
    logic [SUM_W-1:0]       r_acc;
    logic [SUM_W-1:0]       w_res;
    logic [N_LEN-1:0]       w_final;
    logic [OUTS*N_LEN-1:0]  r_q;

    assign w_accept     = i_in_valid & r_in_ready;
    assign w_beat_last  = (r_beat == BEAT_W'(BEATS - 1));
    assign w_frame_last = w_beat_last & (r_elem == ELEM_W'(OUTS - 1));
    assign w_start_ok   = i_start & ((r_state == ST_IDLE) | (r_state == ST_DONE));
    assign w_write      = r_v2 & r_l2;
    assign w_final_wr   = w_write & (r_k == ELEM_W'(OUTS - 1));
    assign w_k_ok       = (r_k <= ELEM_W'(OUTS - 1));

    // Frame sequencing: start is only honoured from IDLE or DONE.
    always_comb begin
        w_state_nx = r_state;
        case (r_state)
            ST_IDLE: begin
                if (i_start) w_state_nx = ST_RUN;
                else         w_state_nx = ST_IDLE;
            end
            ST_RUN: begin
                if (w_accept && w_frame_last) w_state_nx = ST_DRAIN;
                else                          w_state_nx = ST_RUN;
            end
            ST_DRAIN: begin
                if (w_final_wr) w_state_nx = ST_DONE;
                else            w_state_nx = ST_DRAIN;
            end
            ST_DONE: begin
                if (i_start) w_state_nx = ST_RUN;
                else         w_state_nx = ST_DONE;
            end
            default: w_state_nx = ST_IDLE;
        endcase
    end

    // State, registered status outputs and input-side beat/element counters.
    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst) begin
            r_state    <= ST_IDLE;
            r_in_ready <= 1'b0;
            r_busy     <= 1'b0;
            r_valid    <= 1'b0;
            r_beat     <= '0;
            r_elem     <= '0;
        end else begin
            r_state    <= w_state_nx;
            r_in_ready <= (w_state_nx == ST_RUN);
            r_busy     <= (w_state_nx == ST_RUN) | (w_state_nx == ST_DRAIN);
            // valid trails the final write by one edge: DONE must already be reached.
            r_valid    <= (r_state == ST_DONE) & (w_state_nx == ST_DONE);
            if (w_start_ok) begin
                r_beat <= '0;
                r_elem <= '0;
            end else if (w_accept) begin
                if (w_beat_last) begin
                    r_beat <= '0;
                    r_elem <= w_frame_last ? '0 : r_elem + ELEM_W'(1);
                end else begin
                    r_beat <= r_beat + BEAT_W'(1);
                    r_elem <= r_elem;
                end
            end else begin
                r_beat <= r_beat;
                r_elem <= r_elem;
            end
        end
    end

    // Input capture; bias is only meaningful on an element's last beat.
    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst) begin
            r_v0 <= 1'b0;
            r_l0 <= 1'b0;
            r_b0 <= '0;
            r_d  <= '0;
            r_w  <= '0;
        end else if (w_accept) begin
            r_v0 <= 1'b1;
            r_l0 <= w_beat_last;
            r_b0 <= w_beat_last ? i_b : '0;
            r_d  <= i_d;
            r_w  <= i_w;
        end else begin
            r_v0 <= 1'b0;
            r_l0 <= 1'b0;
            r_b0 <= r_b0;
            r_d  <= r_d;
            r_w  <= r_w;
        end
    end

    // Full-width signed products, floor-shifted and sign-extended to the tree width.
    always_comb begin
        logic signed [FULL_W-1:0] w_dx;
        logic signed [FULL_W-1:0] w_wx;
        logic signed [FULL_W-1:0] w_full;
        logic signed [KEEP_W-1:0] w_keep;
        w_prod = '0;
        w_dx   = '0;
        w_wx   = '0;
        w_full = '0;
        w_keep = '0;
        for (int i = 0; i < LANES; i++) begin
            w_dx   = FULL_W'($signed(r_d[i*N_LEN +: N_LEN]));
            w_wx   = FULL_W'($signed(r_w[i*N_LEN_W +: N_LEN_W]));
            w_full = w_dx * w_wx;
            w_keep = KEEP_W'(w_full >>> F_LEN);
            w_prod[i*SUM_W +: SUM_W] = SUM_W'(w_keep);
        end
    end

    // Product stage plus the valid/last/bias tags that ride alongside it.
    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst) begin
            r_prod <= '0;
            r_v1   <= 1'b0;
            r_l1   <= 1'b0;
            r_b1   <= '0;
            r_v2   <= 1'b0;
            r_l2   <= 1'b0;
            r_b2   <= '0;
        end else begin
            r_prod <= w_prod;
            r_v1   <= r_v0;
            r_l1   <= r_l0;
            r_b1   <= r_b0;
            r_v2   <= r_v1;
            r_l2   <= r_l1;
            r_b2   <= r_b1;
        end
    end

    mix_dot_tree #(
        .LANES (LANES),
        .W     (SUM_W)
    ) u_tree (
        .i_clk (i_clk),
        .i_rst (i_rst),
        .i_run (r_busy),
        .i_in  (r_prod),
        .o_sum (w_tree_sum)
    );

    assign w_res = r_acc + w_tree_sum + SUM_W'($signed(r_b2));

`ifdef MIX_DOT_SAT_EN
    function automatic logic [N_LEN-1:0] sat_clamp(input logic [SUM_W-1:0] v);
        logic [SUM_W-N_LEN:0] hi;
        hi = v[SUM_W-1:N_LEN-1];
        if ((&hi) | ~(|hi)) begin
            return v[N_LEN-1:0];
        end else if (v[SUM_W-1]) begin
            return {1'b1, {(N_LEN-1){1'b0}}};
        end else begin
            return {1'b0, {(N_LEN-1){1'b1}}};
        end
    endfunction

    assign w_final = sat_clamp(w_res);
`else
    assign w_final = w_res[N_LEN-1:0];
`endif

    // Accumulate, then write the element and restart the accumulator on its last beat.
    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst) begin
            r_acc <= '0;
            r_k   <= '0;
            r_q   <= '0;
        end else if (w_start_ok) begin
            r_acc <= '0;
            r_k   <= '0;
            r_q   <= '0;
        end else if (w_write) begin
            if (w_k_ok) begin
                r_q[r_k*N_LEN +: N_LEN] <= w_final;
            end else begin
                r_q <= r_q;
            end
            r_acc <= '0;
            r_k   <= (r_k == ELEM_W'(OUTS - 1)) ? r_k : r_k + ELEM_W'(1);
        end else if (r_v2) begin
            r_acc <= r_acc + w_tree_sum;
            r_k   <= r_k;
            r_q   <= r_q;
        end else begin
            r_acc <= r_acc;
            r_k   <= r_k;
            r_q   <= r_q;
        end
    end

    assign o_in_ready = r_in_ready;
    assign o_busy     = r_busy;
    assign o_valid    = r_valid;
    assign o_q        = r_q;

endmodule
